dcache_data_stage: RTL and testbench

Cache (C) stage of the data cache, directly downstream of the TL→C pipeline latch. It consumes the latched address, byte/word flag, hit/miss, hit way and LRU way. On a hit it performs the load/store on the 4-way data array. On a miss it runs a writeback/refill state machine against memory, stalls the core, and returns fill information to the tag-lookup stage.

---
 rtl/dcache_data_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_dcache_data_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_data_stage.sv
// dcache_data_stage -- cache (C) stage of the data cache.
//
// This stage sits after the TL->C pipeline latch. It performs loads and
// stores on the 4-way data array when the access hits. When the access
// misses, it writes back the dirty victim line if there is one. It then
// refills the line from memory. During this time it stalls the core.
// When the refill completes, it tells the tag stage which line it installed.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   c_addr_i ...c_wdata_i latched access from the TL stage (addr, byte flag,
//                         hit way, LRU way, hit, miss, store, store data)
//   rd_data_o/rd_valid_o  load result (a byte load is zero-extended)
//   stall_core_o          holds the core and the TL->C latch
//   mem_*                 line-wide memory port; mem_ack_i is a one-cycle
//                         completion pulse, and mem_rdata_i is valid with it
//   fill_*_o              one-cycle install notice for the tag stage
//
// Optional feature (macro DCACHE_PERF_CNT_EN): adds hit_cnt_o, miss_cnt_o
// and wb_cnt_o. These are free-running 32-bit event counters.
module dcache_data_stage #(
  parameter int LINE_W = 128,
  parameter int SETS   = 4,
  parameter int WORD_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [19:0]         c_addr_i,
  input  logic                c_rqst_byte_i,
  input  logic [1:0]          c_hit_way_i,
  input  logic [1:0]          c_lru_way_i,
  input  logic                c_hit_i,
  input  logic                c_miss_i,
  input  logic                c_wr_i,
  input  logic [WORD_W-1:0]   c_wdata_i,
  output logic [WORD_W-1:0]   rd_data_o,
  output logic                rd_valid_o,
  output logic                stall_core_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [19:0]         mem_addr_o,
  output logic [LINE_W-1:0]   mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [LINE_W-1:0]   mem_rdata_i,
`ifdef DCACHE_PERF_CNT_EN
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o,
  output logic [31:0]         wb_cnt_o,
`endif
  output logic                fill_valid_o,
  output logic [1:0]          fill_way_o,
  output logic [1:0]          fill_index_o,
  output logic [13:0]         fill_tag_o
);

  localparam int ADDR_W = 20;
  localparam int WAYS   = 4;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {IDLE, WB_REQ, FILL_REQ, FILL_DONE} state_t;

  state_t                  state_q;
  logic [WAYS*SETS-1:0]    dirty_q;
  logic [LINE_W-1:0]       data_q [WAYS][SETS];
  logic [TAG_W-1:0]        stag_q [WAYS][SETS];
  logic [1:0]              victim_q;
  logic [LINE_W-1:0]       fill_line_q;

  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic [3:0]              off;
  logic [LINE_W-1:0]       line_hit;
  logic [LINE_W-1:0]       line_vict;
  logic [LINE_W-1:0]       fill_merged;
  logic                    hit_req;

  // Read a word (addr[3:2]) or a zero-extended byte (addr[3:0]) from a line.
  function automatic logic [WORD_W-1:0] read_word(input logic [LINE_W-1:0] line,
                                                  input logic [3:0] o,
                                                  input logic is_byte);
    if (is_byte)
      return {{(WORD_W-8){1'b0}}, line[{o, 3'b000} +: 8]};
    return line[{o[3:2], 5'b00000} +: WORD_W];
  endfunction

  // Merge a byte or word of store data into a line.
  function automatic logic [LINE_W-1:0] merge_store(input logic [LINE_W-1:0] line,
                                                    input logic [3:0] o,
                                                    input logic is_byte,
                                                    input logic [WORD_W-1:0] wd);
    logic [LINE_W-1:0] r;
    r = line;
    if (is_byte)
      r[{o, 3'b000} +: 8] = wd[7:0];
    else
      r[{o[3:2], 5'b00000} +: WORD_W] = wd;
    return r;
  endfunction

  assign idx         = c_addr_i[4 +: IDX_W];
  assign tag         = c_addr_i[ADDR_W-1 -: TAG_W];
  assign off         = c_addr_i[3:0];
  // When miss and hit are both asserted, the miss takes precedence.
  assign hit_req     = c_hit_i & ~c_miss_i;
  assign line_hit    = data_q[c_hit_way_i][idx];
  assign line_vict   = data_q[victim_q][idx];
  assign fill_merged = c_wr_i ? merge_store(fill_line_q, off, c_rqst_byte_i, c_wdata_i)
                              : fill_line_q;

  // Outputs decode from the registered state. Reset forces every output low
  // in the same cycle, so an outstanding request is dropped at once.
  always_comb begin
    rd_data_o    = '0;
    rd_valid_o   = 1'b0;
    stall_core_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    fill_valid_o = 1'b0;
    fill_way_o   = '0;
    fill_index_o = '0;
    fill_tag_o   = '0;
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (c_miss_i) begin
            stall_core_o = 1'b1;
          end else if (hit_req && !c_wr_i) begin
            rd_valid_o = 1'b1;
            rd_data_o  = read_word(line_hit, off, c_rqst_byte_i);
          end
        end
        WB_REQ: begin
          stall_core_o = 1'b1;
          mem_req_o    = 1'b1;
          mem_we_o     = 1'b1;
          mem_addr_o   = {stag_q[victim_q][idx], idx, 4'b0000};
          mem_wdata_o  = line_vict;
        end
        FILL_REQ: begin
          stall_core_o = 1'b1;
          mem_req_o    = 1'b1;
          mem_addr_o   = {c_addr_i[ADDR_W-1:4], 4'b0000};
        end
        FILL_DONE: begin
          fill_valid_o = 1'b1;
          fill_way_o   = victim_q;
          fill_index_o = idx;
          fill_tag_o   = tag;
          if (!c_wr_i) begin
            rd_valid_o = 1'b1;
            rd_data_o  = read_word(fill_merged, off, c_rqst_byte_i);
          end
        end
        default: ;
      endcase
    end
  end

  // Control: miss FSM and dirty bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dirty_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (c_miss_i)
            state_q <= dirty_q[{c_lru_way_i, idx}] ? WB_REQ : FILL_REQ;
          else if (hit_req && c_wr_i)
            dirty_q[{c_hit_way_i, idx}] <= 1'b1;
        end
        WB_REQ:    if (mem_ack_i) state_q <= FILL_REQ;
        FILL_REQ:  if (mem_ack_i) state_q <= FILL_DONE;
        FILL_DONE: begin
          dirty_q[{victim_q, idx}] <= c_wr_i;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath: the arrays have no reset. Writes are suppressed while reset is
  // asserted, so an abandoned miss cannot corrupt a line.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          if (c_miss_i)
            victim_q <= c_lru_way_i;
          else if (hit_req && c_wr_i)
            data_q[c_hit_way_i][idx] <= merge_store(line_hit, off, c_rqst_byte_i, c_wdata_i);
        end
        FILL_REQ: if (mem_ack_i) fill_line_q <= mem_rdata_i;
        FILL_DONE: begin
          data_q[victim_q][idx] <= fill_merged;
          stag_q[victim_q][idx] <= tag;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (state_q == IDLE && hit_req)         hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (state_q == IDLE && c_miss_i)        miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == WB_REQ && mem_ack_i)     wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = rst_i ? 32'd0 : hit_cnt_q;
  assign miss_cnt_o = rst_i ? 32'd0 : miss_cnt_q;
  assign wb_cnt_o   = rst_i ? 32'd0 : wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_data_stage.sv
// Testbench for dcache_data_stage. The bench acts as both the tag stage and
// the memory. Each load pushes its expected result into a queue. A monitor
// pops one entry each time rd_valid_o is seen.
module tb_dcache_data_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [19:0]  c_addr;
  logic         c_rqst_byte;
  logic [1:0]   c_hit_way, c_lru_way;
  logic         c_hit, c_miss, c_wr;
  logic [31:0]  c_wdata;
  logic [31:0]  rd_data;
  logic         rd_valid, stall_core, mem_req, mem_we;
  logic [19:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ack;
  logic         fill_valid;
  logic [1:0]   fill_way, fill_index;
  logic [13:0]  fill_tag;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  dcache_data_stage dut (
    .clk_i(clk), .rst_i(rst), .c_addr_i(c_addr), .c_rqst_byte_i(c_rqst_byte),
    .c_hit_way_i(c_hit_way), .c_lru_way_i(c_lru_way), .c_hit_i(c_hit),
    .c_miss_i(c_miss), .c_wr_i(c_wr), .c_wdata_i(c_wdata),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .stall_core_o(stall_core),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
`ifdef DCACHE_PERF_CNT_EN
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt), .wb_cnt_o(wb_cnt),
`endif
    .fill_valid_o(fill_valid), .fill_way_o(fill_way),
    .fill_index_o(fill_index), .fill_tag_o(fill_tag)
  );

  // Scoreboard monitor: every load result must match the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rd_valid: rd_data=%h with nothing expected", rd_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL load_data: got %h expected %h", rd_data, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    c_addr = '0; c_rqst_byte = 0; c_hit_way = 0; c_lru_way = 0;
    c_hit = 0; c_miss = 0; c_wr = 0; c_wdata = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; drive_idle();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({stall_core, mem_req, mem_we, rd_valid, fill_valid} !== 5'b0) begin
        failures++;
        $display("FAIL reset_ctrl: got %b expected 00000", {stall_core, mem_req, mem_we, rd_valid, fill_valid});
      end
      checks++;
      if ({rd_data, mem_addr, fill_way, fill_index, fill_tag} !== '0 || mem_wdata !== '0) begin
        failures++;
        $display("FAIL reset_data: rd_data=%h mem_addr=%h fill_tag=%h expected all 0", rd_data, mem_addr, fill_tag);
      end
      @(negedge clk);
    end
    rst = 0;
  endtask

  // Load miss to a clean line: it goes straight to FILL_REQ, then to FILL_DONE.
  task automatic test_miss_fill();
    @(negedge clk);
    c_addr = 20'h00124; c_miss = 1; c_lru_way = 2; c_wr = 0; c_rqst_byte = 0;
    #1;
    checks++;
    if ({stall_core, mem_req} !== 2'b10) begin
      failures++;
      $display("FAIL miss_entry: stall/req got %b expected 10", {stall_core, mem_req});
    end
    @(negedge clk); #1;
    checks++;
    if ({mem_req, mem_we, stall_core} !== 3'b101 || mem_addr !== 20'h00120) begin
      failures++;
      $display("FAIL fill_req: req/we/stall=%b addr=%h expected 101 addr=00120", {mem_req, mem_we, stall_core}, mem_addr);
    end
    mem_ack = 1;
    mem_rdata = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    mem_ack = 0; #1;
    checks++;
    if ({fill_valid, fill_way, fill_index, fill_tag, stall_core, mem_req} !== {1'b1, 2'd2, 2'd2, 14'h0004, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL fill_done: valid=%b way=%0d idx=%0d tag=%h stall=%b req=%b expected 1 2 2 0004 0 0",
               fill_valid, fill_way, fill_index, fill_tag, stall_core, mem_req);
    end
    @(negedge clk);
    drive_idle(); #1;
    checks++;
    if (fill_valid !== 1'b0) begin
      failures++;
      $display("FAIL fill_pulse: fill_valid=%b expected 0", fill_valid);
    end
  endtask

  // Byte store hit, followed by word and byte loads of the same line.
  task automatic test_hit_store_load();
    logic [19:0] la [5] = '{20'h00124, 20'h00125, 20'h00127, 20'h00120, 20'h0012C};
    logic        lb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] le [5] = '{32'hA5ADBEEF, 32'h000000BE, 32'h000000A5, 32'h11111111, 32'h33333333};
    @(negedge clk);
    c_hit = 1; c_hit_way = 2; c_addr = 20'h00127; c_rqst_byte = 1; c_wr = 1; c_wdata = 32'hFFFFFFA5;
    #1;
    checks++;
    if ({stall_core, rd_valid} !== 2'b00) begin
      failures++;
      $display("FAIL store_hit: stall/rd_valid got %b expected 00", {stall_core, rd_valid});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      c_addr = la[i]; c_rqst_byte = lb[i]; c_wr = 0;
      exp_q.push_back(le[i]);
      #1;
      checks++;
      if (stall_core !== 1'b0) begin
        failures++;
        $display("FAIL load_hit_stall: addr=%h stall=%b expected 0", la[i], stall_core);
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  // Store miss merges into the refill. The next access hits with no second fill.
  task automatic test_back_to_back();
    @(negedge clk);
    c_addr = 20'h00208; c_miss = 1; c_lru_way = 1; c_wr = 1; c_rqst_byte = 0; c_wdata = 32'hCAFEF00D;
    @(negedge clk); #1;
    checks++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 20'h00200) begin
      failures++;
      $display("FAIL b2b_fill_req: req/we=%b addr=%h expected 10 00200", {mem_req, mem_we}, mem_addr);
    end
    mem_ack = 1;
    mem_rdata = {32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
    @(negedge clk);
    mem_ack = 0; #1;
    checks++;
    if ({fill_valid, fill_way, fill_index, fill_tag} !== {1'b1, 2'd1, 2'd0, 14'h0008}) begin
      failures++;
      $display("FAIL b2b_fill_done: valid=%b way=%0d idx=%0d tag=%h expected 1 1 0 0008", fill_valid, fill_way, fill_index, fill_tag);
    end
    @(negedge clk);
    c_miss = 0; c_hit = 1; c_hit_way = 1; c_wr = 0; c_addr = 20'h00208;
    exp_q.push_back(32'hCAFEF00D);
    #1;
    checks++;
    if ({fill_valid, mem_req, stall_core} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_no_refill: fill/req/stall=%b expected 000", {fill_valid, mem_req, stall_core});
    end
    @(negedge clk);
    c_addr = 20'h00204;
    exp_q.push_back(32'h66666666);
    #1;
    checks++;
    if ({fill_valid, mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_second_hit: fill/req=%b expected 00", {fill_valid, mem_req});
    end
    @(negedge clk);
    drive_idle();
  endtask

  // A miss whose victim is dirty first writes the old line back, then refills.
  task automatic test_writeback();
    @(negedge clk);
    c_addr = 20'h40124; c_miss = 1; c_lru_way = 2; c_wr = 0; c_rqst_byte = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({mem_req, mem_we, stall_core} !== 3'b111 || mem_addr !== 20'h00120 ||
          mem_wdata[63:32] !== 32'hA5ADBEEF || mem_wdata[31:0] !== 32'h11111111) begin
        failures++;
        $display("FAIL wb_req: cyc=%0d req/we/stall=%b addr=%h wdata=%h expected 111 00120 ..A5ADBEEF11111111",
                 i, {mem_req, mem_we, stall_core}, mem_addr, mem_wdata);
      end
    end
    mem_ack = 1;
    mem_rdata = {4{32'h0BAD0BAD}};
    @(negedge clk);
    mem_ack = 0; #1;
    checks++;
    if ({mem_req, mem_we, stall_core} !== 3'b101 || mem_addr !== 20'h40120) begin
      failures++;
      $display("FAIL wb_then_fill: req/we/stall=%b addr=%h expected 101 40120", {mem_req, mem_we, stall_core}, mem_addr);
    end
    mem_ack = 1;
    mem_rdata = {32'h0, 32'h0, 32'h12345678, 32'h0};
    exp_q.push_back(32'h12345678);
    @(negedge clk);
    mem_ack = 0; #1;
    checks++;
    if ({fill_valid, fill_way, fill_index, fill_tag, stall_core} !== {1'b1, 2'd2, 2'd2, 14'h1004, 1'b0}) begin
      failures++;
      $display("FAIL wb_fill_done: valid=%b way=%0d idx=%0d tag=%h stall=%b expected 1 2 2 1004 0",
               fill_valid, fill_way, fill_index, fill_tag, stall_core);
    end
    @(negedge clk);
    drive_idle();
  endtask

  // A late ack: the request must stay stable while the stage waits for it.
  task automatic test_ack_delay();
    @(negedge clk);
    c_addr = 20'h80124; c_miss = 1; c_lru_way = 2; c_wr = 0; c_rqst_byte = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({mem_req, mem_we, stall_core} !== 3'b101 || mem_addr !== 20'h80120) begin
        failures++;
        $display("FAIL ack_wait: cyc=%0d req/we/stall=%b addr=%h expected 101 80120", i, {mem_req, mem_we, stall_core}, mem_addr);
      end
    end
    mem_ack = 1;
    mem_rdata = {32'h0, 32'h0, 32'hFEEDFACE, 32'h0};
    exp_q.push_back(32'hFEEDFACE);
    @(negedge clk);
    mem_ack = 0; #1;
    checks++;
    if ({fill_valid, fill_tag} !== {1'b1, 14'h2004}) begin
      failures++;
      $display("FAIL ack_delay_fill: valid=%b tag=%h expected 1 2004", fill_valid, fill_tag);
    end
    @(negedge clk);
    drive_idle();
  endtask

  // Reset during FILL_REQ: the request drops at once, the miss is discarded,
  // and the dirty bits are cleared.
  task automatic test_reset_midop();
    @(negedge clk);
    c_addr = 20'h00300; c_miss = 1; c_lru_way = 3; c_wr = 0; c_rqst_byte = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 20'h00300) begin
        failures++;
        $display("FAIL rst_pre_wait: cyc=%0d req=%b addr=%h expected 1 00300", i, mem_req, mem_addr);
      end
    end
    @(negedge clk);
    rst = 1; #1;
    checks++;
    if ({mem_req, stall_core} !== 2'b00) begin
      failures++;
      $display("FAIL rst_drop: req/stall=%b expected 00", {mem_req, stall_core});
    end
    @(negedge clk);
    rst = 0; drive_idle(); #1;
    checks++;
    if ({mem_req, stall_core} !== 2'b00) begin
      failures++;
      $display("FAIL rst_after: req/stall=%b expected 00", {mem_req, stall_core});
    end
    mem_ack = 1; mem_rdata = {4{32'hDEAD0000}};
    @(negedge clk);
    mem_ack = 0; #1;
    checks++;
    if ({fill_valid, mem_req, stall_core} !== 3'b000) begin
      failures++;
      $display("FAIL rst_stray_ack: fill/req/stall=%b expected 000", {fill_valid, mem_req, stall_core});
    end
    // Way 1 of set 0 was dirty before the reset; after it, no writeback is expected.
    @(negedge clk);
    c_addr = 20'h10208; c_miss = 1; c_lru_way = 1; c_wr = 0; c_rqst_byte = 0;
    @(negedge clk); #1;
    checks++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 20'h10200) begin
      failures++;
      $display("FAIL rst_dirty_clear: req/we=%b addr=%h expected 10 10200", {mem_req, mem_we}, mem_addr);
    end
    mem_ack = 1;
    mem_rdata = {32'h0, 32'h600DF00D, 32'h0, 32'h0};
    exp_q.push_back(32'h600DF00D);
    @(negedge clk);
    mem_ack = 0; #1;
    checks++;
    if ({fill_valid, fill_way, fill_tag} !== {1'b1, 2'd1, 14'h0408}) begin
      failures++;
      $display("FAIL rst_refill: valid=%b way=%0d tag=%h expected 1 1 0408", fill_valid, fill_way, fill_tag);
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_miss_fill();
    test_hit_store_load();
    test_back_to_back();
    test_writeback();
    test_ack_delay();
    test_reset_midop();
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_loads: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
